alu_arbiter: RTL and testbench

Shares the single ALU between two requesters, nominally the CPU control unit (port 0) and an auxiliary unit such as a debug/coprocessor port (port 1). It arbitrates requests, captures the winning operands and opcode, and drives the ALU's enable/operand inputs. It holds the ALU enable through multi-cycle shift operations and returns the result and comparison flags with a one-cycle acknowledge. It sits between the requesters and the ALU instance in the CPU top level.

---
 rtl/alu_arbiter_if.sv | 42 ++++
 rtl/alu_arbiter.sv | 100 ++++++++++
 tb/tb_alu_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester-side and ALU-side signals of the shared-ALU arbiter.
// slave  = arbiter view, master = environment view (requesters plus ALU).
interface alu_arbiter_if;
  logic        I_req0;
  logic        I_req1;
  logic [31:0] I_s1_0;
  logic [31:0] I_s2_0;
  logic [31:0] I_s1_1;
  logic [31:0] I_s2_1;
  logic [3:0]  I_aluop_0;
  logic [3:0]  I_aluop_1;
  logic        O_ack0;
  logic        O_ack1;
  logic [31:0] O_data;
  logic        O_lt;
  logic        O_ltu;
  logic        O_eq;
  logic        O_alu_en;
  logic        O_alu_reset;
  logic [31:0] O_alu_s1;
  logic [31:0] O_alu_s2;
  logic [3:0]  O_alu_op;
  logic        I_alu_busy;
  logic [31:0] I_alu_data;
  logic        I_alu_lt;
  logic        I_alu_ltu;
  logic        I_alu_eq;

  modport slave (
    input  I_req0, I_req1, I_s1_0, I_s2_0, I_s1_1, I_s2_1, I_aluop_0, I_aluop_1,
    input  I_alu_busy, I_alu_data, I_alu_lt, I_alu_ltu, I_alu_eq,
    output O_ack0, O_ack1, O_data, O_lt, O_ltu, O_eq,
    output O_alu_en, O_alu_reset, O_alu_s1, O_alu_s2, O_alu_op
  );

  modport master (
    output I_req0, I_req1, I_s1_0, I_s2_0, I_s1_1, I_s2_1, I_aluop_0, I_aluop_1,
    output I_alu_busy, I_alu_data, I_alu_lt, I_alu_ltu, I_alu_eq,
    input  O_ack0, O_ack1, O_data, O_lt, O_ltu, O_eq,
    input  O_alu_en, O_alu_reset, O_alu_s1, O_alu_s2, O_alu_op
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between port 0 (control unit) and port 1 (aux unit).
// Latches the winner's operands at grant, enables the ALU for one ISSUE cycle and
// while it reports busy, then returns result/flags with a one-cycle ack.
// Optional: define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration
// (default build is fixed priority, port 0 first).
module alu_arbiter (
  input logic          I_clk,
  input logic          I_reset_n,
  alu_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        win_q;
  logic [31:0] s1_q, s2_q;
  logic [3:0]  op_q;
  logic        alu_rst_q;
  logic        grant;
  logic        gnt_port;
  logic        done;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic last_q;

  // Round-robin pick: on a tie the port not granted last wins.
  always_comb begin
    if (bus.I_req0 && bus.I_req1) gnt_port = ~last_q;
    else                          gnt_port = ~bus.I_req0;
  end

  // Last-granted pointer; resets to port 1 so port 0 takes the first tie.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n)  last_q <= 1'b1;
    else if (grant)  last_q <= gnt_port;
  end
`else
  // Fixed priority pick: port 1 only when port 0 is not requesting.
  always_comb gnt_port = ~bus.I_req0;
`endif

  // Next-state logic; a grant happens only when leaving IDLE.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.I_req0 || bus.I_req1) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    if (!bus.I_alu_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, winner index and operands captured at grant.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      s1_q    <= '0;
      s2_q    <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        win_q <= gnt_port;
        s1_q  <= gnt_port ? bus.I_s1_1    : bus.I_s1_0;
        s2_q  <= gnt_port ? bus.I_s2_1    : bus.I_s2_0;
        op_q  <= gnt_port ? bus.I_aluop_1 : bus.I_aluop_0;
      end
    end
  end

  // ALU reset follows I_reset_n asynchronously and stays high one clock past release.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) alu_rst_q <= 1'b1;
    else            alu_rst_q <= 1'b0;
  end

  // Enable drops together with busy so a finished shift is not restarted.
  assign done            = (state_q == WAIT) && !bus.I_alu_busy;
  assign bus.O_alu_en    = (state_q == ISSUE) || ((state_q == WAIT) && bus.I_alu_busy);
  assign bus.O_ack0      = done && !win_q;
  assign bus.O_ack1      = done &&  win_q;
  assign bus.O_data      = done ? bus.I_alu_data : '0;
  assign bus.O_lt        = done && bus.I_alu_lt;
  assign bus.O_ltu       = done && bus.I_alu_ltu;
  assign bus.O_eq        = done && bus.I_alu_eq;
  assign bus.O_alu_reset = alu_rst_q;
  assign bus.O_alu_s1    = s1_q;
  assign bus.O_alu_s2    = s2_q;
  assign bus.O_alu_op    = op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter with a behavioural ALU
// (optional multi-cycle shifts) and a transaction-level arbitration model.
module tb_alu_arbiter;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   model_last = 1;
  int unsigned cyc = 0;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .I_clk     (clk),
    .I_reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected ALU function (opcodes: 0 ADD 1 SUB 2 SLL 3 SRL 4 SRA 5 AND 6 OR else XOR)
  function automatic logic [31:0] ref_data(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << b[4:0];
      4'd3:    return a >> b[4:0];
      4'd4:    return $unsigned($signed(a) >>> b[4:0]);
      4'd5:    return a & b;
      4'd6:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic bit is_shift(input logic [3:0] op);
    return (op == 4'd2) || (op == 4'd3) || (op == 4'd4);
  endfunction

  // Behavioural ALU: starts on enable when idle; shifts stay busy k+1 cycles in multi mode.
  bit          alu_multi = 1'b0;
  int unsigned alu_cnt   = 0;
  logic [31:0] alu_res   = '0;
  logic        alu_lt = 1'b0, alu_ltu = 1'b0, alu_eq = 1'b0;

  always @(posedge clk) begin
    if (bus.O_alu_reset) begin
      alu_cnt <= 0;
    end else if (alu_cnt != 0) begin
      alu_cnt <= alu_cnt - 1;
    end else if (bus.O_alu_en) begin
      alu_res <= ref_data(bus.O_alu_op, bus.O_alu_s1, bus.O_alu_s2);
      alu_lt  <= $signed(bus.O_alu_s1) < $signed(bus.O_alu_s2);
      alu_ltu <= bus.O_alu_s1 < bus.O_alu_s2;
      alu_eq  <= bus.O_alu_s1 == bus.O_alu_s2;
      alu_cnt <= (alu_multi && is_shift(bus.O_alu_op)) ? 32'(bus.O_alu_s2[4:0]) + 1 : 0;
    end
  end

  assign bus.I_alu_busy = (alu_cnt != 0);
  assign bus.I_alu_data = alu_res;
  assign bus.I_alu_lt   = alu_lt;
  assign bus.I_alu_ltu  = alu_ltu;
  assign bus.I_alu_eq   = alu_eq;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request on one port; new operands are driven right after the grant.
  task automatic run_op(input int port, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [31:0] na, input logic [31:0] nb);
    logic [31:0] ed;
    logic        el, elu, ee;
    int          lat, c, en_cnt;
    bit          got;
    ed  = ref_data(op, a, b);
    el  = $signed(a) < $signed(b);
    elu = a < b;
    ee  = a == b;
    lat = (alu_multi && is_shift(op)) ? 3 + int'(b[4:0]) : 2;
    if (port == 0) begin
      bus.I_s1_0 = a; bus.I_s2_0 = b; bus.I_aluop_0 = op; bus.I_req0 = 1'b1;
    end else begin
      bus.I_s1_1 = a; bus.I_s2_1 = b; bus.I_aluop_1 = op; bus.I_req1 = 1'b1;
    end
    tick();
    checks++;
    if (bus.O_alu_s1 !== a || bus.O_alu_s2 !== b || bus.O_alu_op !== op) begin
      errors++;
      $display("FAIL latch: got s1=%0h s2=%0h op=%0h expected s1=%0h s2=%0h op=%0h",
               bus.O_alu_s1, bus.O_alu_s2, bus.O_alu_op, a, b, op);
    end
    checks++;
    if (bus.O_data !== 32'd0 || bus.O_lt !== 1'b0 || bus.O_ltu !== 1'b0 || bus.O_eq !== 1'b0) begin
      errors++;
      $display("FAIL idle_data: got data=%0h flags=%b%b%b expected 0", bus.O_data, bus.O_lt, bus.O_ltu, bus.O_eq);
    end
    bus.I_req0 = 1'b0;
    bus.I_req1 = 1'b0;
    if (port == 0) begin bus.I_s1_0 = na; bus.I_s2_0 = nb; end
    else           begin bus.I_s1_1 = na; bus.I_s2_1 = nb; end
    c = 1; got = 1'b0; en_cnt = 0;
    while (!got && c < 50) begin
      if (bus.O_ack0 || bus.O_ack1) begin
        got = 1'b1;
        checks++;
        if (c != lat) begin
          errors++;
          $display("FAIL ack_latency: got %0d expected %0d", c, lat);
        end
        checks++;
        if (bus.O_ack0 !== (port == 0) || bus.O_ack1 !== (port == 1)) begin
          errors++;
          $display("FAIL ack_port: got ack0=%b ack1=%b expected port %0d", bus.O_ack0, bus.O_ack1, port);
        end
        checks++;
        if (bus.O_data !== ed || bus.O_lt !== el || bus.O_ltu !== elu || bus.O_eq !== ee) begin
          errors++;
          $display("FAIL result: got %0h lt=%b ltu=%b eq=%b expected %0h lt=%b ltu=%b eq=%b",
                   bus.O_data, bus.O_lt, bus.O_ltu, bus.O_eq, ed, el, elu, ee);
        end
        checks++;
        if (bus.O_alu_en !== 1'b0) begin
          errors++;
          $display("FAIL en_at_ack: got %b expected 0", bus.O_alu_en);
        end
      end else begin
        if (bus.O_alu_en === 1'b1) en_cnt++;
        tick();
        c++;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout: got no ack expected ack within 50 cycles");
    end
    checks++;
    if (en_cnt != lat - 1) begin
      errors++;
      $display("FAIL en_cycles: got %0d expected %0d", en_cnt, lat - 1);
    end
    model_last = port;
    tick();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.O_ack0 !== 1'b0 || bus.O_ack1 !== 1'b0 || bus.O_alu_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got ack0=%b ack1=%b en=%b expected 000", bus.O_ack0, bus.O_ack1, bus.O_alu_en);
    end
    checks++;
    if (bus.O_alu_s1 !== 32'd0 || bus.O_alu_s2 !== 32'd0 || bus.O_alu_op !== 4'd0) begin
      errors++;
      $display("FAIL reset_operands: got %0h %0h %0h expected 0", bus.O_alu_s1, bus.O_alu_s2, bus.O_alu_op);
    end
    checks++;
    if (bus.O_data !== 32'd0 || bus.O_lt !== 1'b0 || bus.O_ltu !== 1'b0 || bus.O_eq !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: got %0h expected 0", bus.O_data);
    end
    checks++;
    if (bus.O_alu_reset !== 1'b1) begin
      errors++;
      $display("FAIL reset_alu_reset: got %b expected 1", bus.O_alu_reset);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.O_alu_reset !== 1'b1) begin
      errors++;
      $display("FAIL alu_reset_hold: got %b expected 1", bus.O_alu_reset);
    end
    tick();
    checks++;
    if (bus.O_alu_reset !== 1'b0) begin
      errors++;
      $display("FAIL alu_reset_release: got %b expected 0", bus.O_alu_reset);
    end
    model_last = 1;
  endtask

  task automatic test_add();
    alu_multi = 1'b0;
    run_op(0, 32'd5, 32'd7, 4'd0, 32'd5, 32'd7);
  endtask

  task automatic test_sll_multi();
    alu_multi = 1'b1;
    run_op(1, 32'd1, 32'd4, 4'd2, 32'd1, 32'd4);
  endtask

  task automatic test_operand_change();
    alu_multi = 1'b0;
    run_op(0, 32'd9, 32'd9, 4'd1, 32'd3, 32'd7);
  endtask

  // Both ports request; port 0 drops for the last grant.
  task automatic test_arbitration();
    int  exp_port, got_port, c;
    bit  got, r0;
    alu_multi = 1'b0;
    bus.I_s1_0 = 32'd1;  bus.I_s2_0 = 32'd2;  bus.I_aluop_0 = 4'd0;
    bus.I_s1_1 = 32'd10; bus.I_s2_1 = 32'd20; bus.I_aluop_1 = 4'd0;
    bus.I_req0 = 1'b1;
    bus.I_req1 = 1'b1;
    for (int g = 0; g < 5; g++) begin
      r0 = (g < 4);
      bus.I_req0 = r0;
      if (r0) exp_port = RR ? (model_last == 1 ? 0 : 1) : 0;
      else    exp_port = 1;
      model_last = exp_port;
      got = 1'b0; c = 0;
      while (!got && c < 20) begin
        tick();
        c++;
        if (bus.O_ack0 || bus.O_ack1) got = 1'b1;
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL arb_timeout: got no ack expected ack in grant %0d", g);
      end else begin
        got_port = bus.O_ack1 ? 1 : 0;
        checks++;
        if (got_port != exp_port || c != 2) begin
          errors++;
          $display("FAIL arb_order: got port %0d after %0d cycles expected port %0d after 2", got_port, c, exp_port);
        end
        checks++;
        if (bus.O_data !== (exp_port == 1 ? 32'd30 : 32'd3)) begin
          errors++;
          $display("FAIL arb_data: got %0h expected %0h", bus.O_data, (exp_port == 1 ? 32'd30 : 32'd3));
        end
      end
      if (g == 4) bus.I_req1 = 1'b0;
      tick();
    end
  endtask

  // Port 0 re-requests in the IDLE cycle right after its ack.
  task automatic test_back_to_back();
    int unsigned t1, t2;
    int c;
    bit got;
    alu_multi = 1'b0;
    bus.I_s1_0 = 32'd40; bus.I_s2_0 = 32'd2; bus.I_aluop_0 = 4'd0;
    bus.I_req0 = 1'b1;
    t1 = 0; t2 = 0;
    got = 1'b0; c = 0;
    while (!got && c < 20) begin
      tick(); c++;
      if (bus.O_ack0) begin got = 1'b1; t1 = cyc; end
    end
    tick();
    bus.I_s1_0 = 32'd100; bus.I_s2_0 = 32'd11; bus.I_aluop_0 = 4'd1;
    tick();
    bus.I_req0 = 1'b0;
    got = 1'b0; c = 0;
    while (!got && c < 20) begin
      if (bus.O_ack0) begin got = 1'b1; t2 = cyc; end
      else begin tick(); c++; end
    end
    checks++;
    if (!got || t2 - t1 != 3) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles expected 3", t2 - t1);
    end
    checks++;
    if (bus.O_data !== 32'd89) begin
      errors++;
      $display("FAIL b2b_data: got %0h expected 59", bus.O_data);
    end
    model_last = 0;
    tick();
  endtask

  task automatic test_reset_mid_shift();
    int acks;
    alu_multi = 1'b1;
    bus.I_s1_1 = 32'd1; bus.I_s2_1 = 32'd10; bus.I_aluop_1 = 4'd2;
    bus.I_req1 = 1'b1;
    tick();
    bus.I_req1 = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.O_alu_reset !== 1'b1 || bus.O_alu_en !== 1'b0 || bus.O_ack0 !== 1'b0 ||
        bus.O_ack1 !== 1'b0 || bus.O_alu_s1 !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset: got rst=%b en=%b acks=%b%b s1=%0h expected 1 0 00 0",
               bus.O_alu_reset, bus.O_alu_en, bus.O_ack0, bus.O_ack1, bus.O_alu_s1);
    end
    tick(); tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.O_alu_reset !== 1'b1) begin
      errors++;
      $display("FAIL mid_alu_reset_hold: got %b expected 1", bus.O_alu_reset);
    end
    tick();
    checks++;
    if (bus.O_alu_reset !== 1'b0) begin
      errors++;
      $display("FAIL mid_alu_reset_release: got %b expected 0", bus.O_alu_reset);
    end
    acks = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.O_ack0 || bus.O_ack1 || bus.O_alu_en) acks++;
      tick();
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL aborted_ack: got %0d active cycles expected 0", acks);
    end
    model_last = 1;
    alu_multi = 1'b0;
    run_op(0, 32'd100, 32'd23, 4'd0, 32'd1, 32'd1);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [3:0]  op;
    int          port;
    for (int i = 0; i < 14; i++) begin
      alu_multi = ($urandom_range(0, 1) == 1);
      port      = int'($urandom_range(0, 1));
      op        = 4'($urandom_range(0, 7));
      a         = $urandom;
      b         = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      run_op(port, a, b, op, $urandom, $urandom);
    end
  endtask

  initial begin
    bus.I_req0 = 1'b0; bus.I_req1 = 1'b0;
    bus.I_s1_0 = '0; bus.I_s2_0 = '0; bus.I_s1_1 = '0; bus.I_s2_1 = '0;
    bus.I_aluop_0 = '0; bus.I_aluop_1 = '0;
    test_reset();
    test_add();
    test_sll_multi();
    test_operand_change();
    test_arbitration();
    test_back_to_back();
    test_reset_mid_shift();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
